// File: rtl/gt_vortex_ctrl_pkg.sv
// gt_vortex_ctrl_pkg: register map, field positions and limit defaults for the Vortex AXI control shim
package gt_vortex_ctrl_pkg;
    localparam logic [5:0] OFF_CTRL        = 6'h00;
    localparam logic [5:0] OFF_STATUS      = 6'h01;
    localparam logic [5:0] OFF_LIMIT       = 6'h02;
    localparam logic [5:0] OFF_RD_BURSTS   = 6'h03;
    localparam logic [5:0] OFF_WR_BURSTS   = 6'h04;
    localparam logic [5:0] OFF_BUSY_CYCLES = 6'h05;
    localparam int CTRL_EN       = 0;
    localparam int CTRL_SOFT_RST = 1;
    localparam int CTRL_IRQ_EN   = 2;
    localparam int CTRL_CLR_CNT  = 3;
    localparam int ST_BUSY       = 0;
    localparam int ST_DONE       = 1;
    localparam int ST_UNDERFLOW  = 2;
    localparam int LIM_RD        = 0;
    localparam int LIM_WR        = 8;
    // An out-of-range default limit falls back to 16 rather than producing a dead (0) or truncated limit.
    function automatic logic [7:0] max_out_init(input int v);
        return (v >= 1 && v <= 255) ? v[7:0] : 8'd16;
    endfunction
endpackage

// File: rtl/axi_outstanding_tracker.sv
// axi_outstanding_tracker: gates one AXI address channel by an outstanding limit and counts completed bursts
// Ports: i_soft clears count/gate and ignores responses; i_en/i_max set issue policy;
//        i_core_valid/i_m_ready in, o_m_valid/o_core_ready gated out; i_resp_hs is a completing response;
//        o_out outstanding count, o_uf sticky underflow (cleared by i_uf_clr), o_bursts saturating burst count.
module axi_outstanding_tracker
    import gt_vortex_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_soft,
    input  logic             i_en,
    input  logic [7:0]       i_max,
    input  logic             i_core_valid,
    input  logic             i_m_ready,
    input  logic             i_resp_hs,
    input  logic             i_cnt_clr,
    input  logic             i_uf_clr,
    output logic             o_m_valid,
    output logic             o_core_ready,
    output logic [7:0]       o_out,
    output logic             o_uf,
    output logic [CNT_W-1:0] o_bursts
);
    logic             r_gate;
    logic [7:0]       r_out;
    logic             r_uf;
    logic [CNT_W-1:0] r_bursts;
    logic             w_hs;
    logic             w_resp;
    logic             w_uf_ev;
    logic             w_pend;
    logic [7:0]       w_out_nx;

    assign o_m_valid    = i_core_valid & r_gate;
    assign o_core_ready = i_m_ready & r_gate;
    assign o_out        = r_out;
    assign o_uf         = r_uf;
    assign o_bursts     = r_bursts;
    assign w_hs         = o_m_valid & i_m_ready;
    assign w_resp       = i_resp_hs & !i_soft;
    assign w_uf_ev      = w_resp & (r_out == 8'd0);
    assign w_out_nx     = r_out + {7'd0, w_hs} - {7'd0, w_resp & !w_uf_ev};
    assign w_pend       = o_m_valid & !i_m_ready;

    // The gate looks at the post-update count so a handshake that reaches the limit closes it immediately;
    // a pending valid keeps the gate open so the AXI valid is never withdrawn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gate   <= 1'b0;
            r_out    <= 8'd0;
            r_uf     <= 1'b0;
            r_bursts <= '0;
        end else begin
            r_gate   <= i_soft ? 1'b0 : (w_pend | (i_en & (w_out_nx < i_max)));
            r_out    <= i_soft ? 8'd0 : w_out_nx;
            r_uf     <= w_uf_ev | (r_uf & !i_uf_clr);
            r_bursts <= i_cnt_clr ? '0 : (w_resp & ~&r_bursts) ? r_bursts + CNT_W'(1) : r_bursts;
        end
    end
endmodule

// File: rtl/gt_vortex_axi_ctrl_shim.sv
// gt_vortex_axi_ctrl_shim: APB control/monitor shim gating Vortex AR/AW issue towards the NoC AXI port
// Ports: clk, reset (async active-low); APB slave psel/penable/pwrite/paddr/pwdata -> prdata/pready/pslverr;
//        core_ar/awvalid -> m_axi_ar/awvalid and m_axi_ar/awready -> core_ar/awready (gated);
//        observed R (rvalid/rready/rlast) and B (bvalid/bready); core_busy in; core_reset_n and irq out.
module gt_vortex_axi_ctrl_shim
    import gt_vortex_ctrl_pkg::*;
#(
    parameter int MAX_OUT_DEFAULT = 16,
    parameter int CNT_W           = 32,
    parameter int REG_BASE        = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    input  logic        core_arvalid,
    input  logic        core_awvalid,
    output logic        core_arready,
    output logic        core_awready,
    output logic        m_axi_arvalid,
    output logic        m_axi_awvalid,
    input  logic        m_axi_arready,
    input  logic        m_axi_awready,
    input  logic        m_axi_rvalid,
    input  logic        m_axi_rready,
    input  logic        m_axi_rlast,
    input  logic        m_axi_bvalid,
    input  logic        m_axi_bready,
    input  logic        core_busy,
    output logic        core_reset_n,
    output logic        irq
);
    localparam logic [7:0] MAX_INIT = max_out_init(MAX_OUT_DEFAULT);

    logic [2:0]       r_ctrl;
    logic [7:0]       r_max_rd;
    logic [7:0]       r_max_wr;
    logic [CNT_W-1:0] r_busy_cyc;
    logic             r_busy_q;
    logic             r_done;
    logic             r_irq;
    logic             r_core_rst_n;
    logic [31:0]      r_prdata;
    logic [31:0]      w_rel;
    logic [5:0]       w_off;
    logic             w_setup;
    logic             w_access;
    logic             w_mapped;
    logic             w_wr;
    logic             w_clr;
    logic             w_st_wr;
    logic [7:0]       w_rd_out;
    logic [7:0]       w_wr_out;
    logic             w_rd_uf;
    logic             w_wr_uf;
    logic [CNT_W-1:0] w_rd_bursts;
    logic [CNT_W-1:0] w_wr_bursts;
    logic [31:0]      w_rdata;
    logic             w_unused;

    assign w_rel    = paddr - 32'(REG_BASE);
    assign w_off    = w_rel[7:2];
    assign w_setup  = psel & !penable;
    assign w_access = psel & penable;
    assign w_mapped = (w_rel[31:8] == 24'd0) && (w_off <= OFF_BUSY_CYCLES);
    assign w_wr     = w_access & pwrite & w_mapped;
    assign w_clr    = w_wr && (w_off == OFF_CTRL) && pwdata[CTRL_CLR_CNT];
    assign w_st_wr  = w_wr && (w_off == OFF_STATUS);
    assign w_unused = ^{w_rel[1:0], pwdata[31:16]};

    assign pready       = w_access;
    assign pslverr      = w_access & !w_mapped;
    assign prdata       = r_prdata;
    assign irq          = r_irq;
    assign core_reset_n = r_core_rst_n;

    axi_outstanding_tracker #(.CNT_W(CNT_W)) u_rd (
        .clk(clk), .rst_n(reset), .i_soft(r_ctrl[CTRL_SOFT_RST]), .i_en(r_ctrl[CTRL_EN]), .i_max(r_max_rd),
        .i_core_valid(core_arvalid), .i_m_ready(m_axi_arready),
        .i_resp_hs(m_axi_rvalid & m_axi_rready & m_axi_rlast),
        .i_cnt_clr(w_clr), .i_uf_clr(w_st_wr & pwdata[ST_UNDERFLOW]),
        .o_m_valid(m_axi_arvalid), .o_core_ready(core_arready), .o_out(w_rd_out), .o_uf(w_rd_uf),
        .o_bursts(w_rd_bursts)
    );

    axi_outstanding_tracker #(.CNT_W(CNT_W)) u_wr (
        .clk(clk), .rst_n(reset), .i_soft(r_ctrl[CTRL_SOFT_RST]), .i_en(r_ctrl[CTRL_EN]), .i_max(r_max_wr),
        .i_core_valid(core_awvalid), .i_m_ready(m_axi_awready),
        .i_resp_hs(m_axi_bvalid & m_axi_bready),
        .i_cnt_clr(w_clr), .i_uf_clr(w_st_wr & pwdata[ST_UNDERFLOW]),
        .o_m_valid(m_axi_awvalid), .o_core_ready(core_awready), .o_out(w_wr_out), .o_uf(w_wr_uf),
        .o_bursts(w_wr_bursts)
    );

    // clr_cnt is never stored, so CTRL[3] always reads back 0.
    always_comb begin
        w_rdata = 32'd0;
        case (w_off)
            OFF_CTRL:        w_rdata = {29'd0, r_ctrl};
            OFF_STATUS:      w_rdata = {8'd0, w_wr_out, w_rd_out, 5'd0, w_rd_uf | w_wr_uf, r_done, core_busy};
            OFF_LIMIT:       w_rdata = {16'd0, r_max_wr, r_max_rd};
            OFF_RD_BURSTS:   w_rdata = w_rd_bursts[31:0];
            OFF_WR_BURSTS:   w_rdata = w_wr_bursts[31:0];
            OFF_BUSY_CYCLES: w_rdata = r_busy_cyc[31:0];
            default:         w_rdata = 32'd0;
        endcase
        if (!w_mapped) w_rdata = 32'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ctrl       <= 3'd0;
            r_max_rd     <= MAX_INIT;
            r_max_wr     <= MAX_INIT;
            r_busy_cyc   <= '0;
            r_busy_q     <= 1'b0;
            r_done       <= 1'b0;
            r_irq        <= 1'b0;
            r_core_rst_n <= 1'b0;
            r_prdata     <= 32'd0;
        end else begin
            if (w_wr && w_off == OFF_CTRL) r_ctrl <= pwdata[2:0];
            if (w_wr && w_off == OFF_LIMIT) begin
                r_max_rd <= pwdata[LIM_RD +: 8];
                r_max_wr <= pwdata[LIM_WR +: 8];
            end
            r_busy_cyc   <= w_clr ? '0 : (core_busy & ~&r_busy_cyc) ? r_busy_cyc + CNT_W'(1) : r_busy_cyc;
            r_busy_q     <= core_busy;
            // A new falling edge beats a coincident W1C so the completion is not lost.
            r_done       <= (r_busy_q & !core_busy) | (r_done & !(w_st_wr & pwdata[ST_DONE]));
            r_irq        <= r_done & r_ctrl[CTRL_IRQ_EN];
            r_core_rst_n <= !r_ctrl[CTRL_SOFT_RST];
            r_prdata     <= w_setup ? w_rdata : w_access ? r_prdata : 32'd0;
        end
    end
endmodule

// File: tb/tb_gt_vortex_axi_ctrl_shim.sv
// tb_gt_vortex_axi_ctrl_shim: directed bench with an APB read scoreboard and direct signal checks
module tb_gt_vortex_axi_ctrl_shim;
    logic        clk = 1'b0, reset = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0, prdata;
    logic        pready, pslverr;
    logic        core_arvalid = 1'b0, core_awvalid = 1'b0, core_arready, core_awready;
    logic        m_axi_arvalid, m_axi_awvalid;
    logic        m_axi_arready = 1'b0, m_axi_awready = 1'b0;
    logic        m_axi_rvalid = 1'b0, m_axi_rready = 1'b0, m_axi_rlast = 1'b0;
    logic        m_axi_bvalid = 1'b0, m_axi_bready = 1'b0;
    logic        core_busy = 1'b0, core_reset_n, irq;

    always #5 clk = ~clk;

    gt_vortex_axi_ctrl_shim dut (
        .clk(clk), .reset(reset), .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .core_arvalid(core_arvalid), .core_awvalid(core_awvalid), .core_arready(core_arready),
        .core_awready(core_awready), .m_axi_arvalid(m_axi_arvalid), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_arready(m_axi_arready), .m_axi_awready(m_axi_awready), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready), .m_axi_rlast(m_axi_rlast), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready), .core_busy(core_busy), .core_reset_n(core_reset_n), .irq(irq)
    );

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, errors = 0, ar_hs = 0, aw_hs = 0;

    always @(negedge clk) begin
        exp_t e;
        if (m_axi_arvalid && m_axi_arready) ar_hs++;
        if (m_axi_awvalid && m_axi_awready) aw_hs++;
        if (psel && penable && !pwrite) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected got prdata=%h with no expectation queued", prdata);
            end else begin
                e = sb.pop_front();
                if (prdata !== e.data || pslverr !== e.err || pready !== 1'b1) begin
                    errors++;
                    $display("FAIL %s got prdata=%h pslverr=%b pready=%b want prdata=%h pslverr=%b pready=1",
                             e.name, prdata, pslverr, pready, e.data, e.err);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d, input bit drop_busy);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        if (drop_busy) core_busy = 1'b0;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, input logic [31:0] d, input logic e, input string name);
        sb.push_back('{name, d, e});
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic r_pulse(input int n);
        m_axi_rvalid = 1'b1; m_axi_rready = 1'b1; m_axi_rlast = 1'b1;
        cyc(n);
        m_axi_rvalid = 1'b0; m_axi_rready = 1'b0; m_axi_rlast = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        #22;
        chk("rst_core_reset_n", {31'd0, core_reset_n}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_prdata", prdata, 32'd0);
        chk("rst_pslverr", {31'd0, pslverr}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        chk("core_reset_n_before_edge", {31'd0, core_reset_n}, 32'd0);
        cyc(1);
        chk("core_reset_n_release", {31'd0, core_reset_n}, 32'd1);
        apb_read(32'h08, 32'h0000_1010, 1'b0, "limit_reset");

        apb_write(32'h00, 32'h1, 1'b0);
        apb_write(32'h08, 32'h0202, 1'b0);
        core_arvalid = 1'b1; m_axi_arready = 1'b1;
        cyc(4);
        chk("ar_two_issued", ar_hs, 2);
        @(negedge clk);
        chk("ar_third_blocked", {31'd0, m_axi_arvalid}, 32'd0);
        @(posedge clk); #1;
        apb_read(32'h04, 32'h0000_0200, 1'b0, "status_rd_out2");
        r_pulse(1);
        found = 1'b0;
        for (int i = 0; i < 3 && !found; i++) begin
            @(negedge clk);
            if (m_axi_arvalid) found = 1'b1;
        end
        chk("ar_third_after_rlast", {31'd0, found}, 32'd1);
        @(posedge clk); #1;
        core_arvalid = 1'b0; m_axi_arready = 1'b0;
        chk("ar_three_total", ar_hs, 3);
        apb_read(32'h0C, 32'd1, 1'b0, "rd_bursts_1");

        r_pulse(2);
        core_arvalid = 1'b1;
        cyc(1);
        apb_write(32'h00, 32'h0, 1'b0);
        @(negedge clk);
        chk("ar_pending_held", {31'd0, m_axi_arvalid}, 32'd1);
        @(posedge clk); #1;
        m_axi_arready = 1'b1;
        cyc(1);
        m_axi_arready = 1'b0;
        @(negedge clk);
        chk("ar_dropped_after_hs", {31'd0, m_axi_arvalid}, 32'd0);
        @(posedge clk); #1;
        core_arvalid = 1'b0;
        chk("ar_four_total", ar_hs, 4);

        apb_write(32'h00, 32'h1, 1'b0);
        cyc(1);
        core_arvalid = 1'b1; m_axi_arready = 1'b1;
        m_axi_rvalid = 1'b1; m_axi_rready = 1'b1; m_axi_rlast = 1'b1;
        cyc(1);
        core_arvalid = 1'b0; m_axi_arready = 1'b0;
        m_axi_rvalid = 1'b0; m_axi_rready = 1'b0; m_axi_rlast = 1'b0;
        chk("ar_simul_hs", ar_hs, 5);
        apb_read(32'h04, 32'h0000_0100, 1'b0, "status_simul_rd_out1");
        apb_read(32'h0C, 32'd4, 1'b0, "rd_bursts_simul");

        r_pulse(2);
        apb_read(32'h04, 32'h0000_0004, 1'b0, "status_underflow");
        apb_read(32'h0C, 32'd6, 1'b0, "rd_bursts_6");
        apb_read(32'h3C, 32'd0, 1'b1, "unmapped_slverr");
        apb_write(32'h04, 32'h4, 1'b0);
        apb_read(32'h04, 32'h0, 1'b0, "status_uf_cleared");

        apb_write(32'h00, 32'h5, 1'b0);
        core_busy = 1'b1;
        cyc(100);
        core_busy = 1'b0;
        cyc(2);
        chk("irq_on_done", {31'd0, irq}, 32'd1);
        apb_read(32'h04, 32'h0000_0002, 1'b0, "status_done");
        apb_read(32'h14, 32'd100, 1'b0, "busy_cycles_100");
        apb_write(32'h04, 32'h2, 1'b0);
        cyc(1);
        chk("irq_cleared", {31'd0, irq}, 32'd0);
        apb_read(32'h04, 32'h0, 1'b0, "status_done_cleared");

        core_busy = 1'b1;
        cyc(1);
        apb_write(32'h04, 32'h2, 1'b1);
        apb_read(32'h04, 32'h0000_0002, 1'b0, "status_done_set_wins");
        chk("irq_set_wins", {31'd0, irq}, 32'd1);
        apb_read(32'h14, 32'd102, 1'b0, "busy_cycles_102");

        apb_write(32'h00, 32'hD, 1'b0);
        apb_read(32'h14, 32'd0, 1'b0, "busy_cleared");
        apb_read(32'h0C, 32'd0, 1'b0, "rd_bursts_cleared");
        apb_read(32'h00, 32'h5, 1'b0, "ctrl_clr_reads0");

        apb_write(32'h08, 32'h0000, 1'b0);
        cyc(2);
        core_awvalid = 1'b1; m_axi_awready = 1'b1;
        cyc(4);
        chk("aw_max0_blocked", aw_hs, 0);
        apb_write(32'h08, 32'h0100, 1'b0);
        cyc(4);
        core_awvalid = 1'b0; m_axi_awready = 1'b0;
        chk("aw_one_issued", aw_hs, 1);
        apb_read(32'h04, 32'h0001_0002, 1'b0, "status_wr_out1");
        m_axi_bvalid = 1'b1; m_axi_bready = 1'b1;
        cyc(1);
        m_axi_bvalid = 1'b0; m_axi_bready = 1'b0;
        apb_read(32'h10, 32'd1, 1'b0, "wr_bursts_1");
        apb_read(32'h04, 32'h0000_0002, 1'b0, "status_wr_drained");

        apb_write(32'h00, 32'h7, 1'b0);
        cyc(1);
        chk("soft_rst_core_reset_n", {31'd0, core_reset_n}, 32'd0);
        apb_read(32'h08, 32'h0000_0100, 1'b0, "limit_kept_soft");
        apb_read(32'h00, 32'h7, 1'b0, "ctrl_soft");
        apb_write(32'h00, 32'h5, 1'b0);
        cyc(1);
        chk("soft_rst_release", {31'd0, core_reset_n}, 32'd1);

        cyc(3);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/gt_vortex_axi_ctrl_shim.md
Name: gt_vortex_axi_ctrl_shim

Overview:
- Control/monitor shim between the Vortex AXI master and the ESP NoC-facing AXI port; it is the successor to the earlier tie-off wrapper, which left the APB slave dead.
- Provides a live APB register slave with enable, soft reset, done/IRQ, per-direction outstanding-transaction limits and performance counters.
- Gates only AR/AW valid/ready. It observes R/B handshakes.
- Payload fields (addr, id, len, data, ...) are wired around this block by the parent wrapper.

Parameters:
- MAX_OUT_DEFAULT, 16, reset value of both outstanding limits (1..255).
- CNT_W, 32, width of burst and cycle counters (32..64; reads return the low 32 bits).
- REG_BASE, 0, APB base offset; decode uses paddr[7:2] relative to it.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- psel, penable, pwrite  in  1  APB control
- paddr  in  32  APB address
- pwdata  in  32  APB write data
- prdata  out  32  APB read data
- pready  out  1  APB ready
- pslverr  out  1  APB error
- core_arvalid, core_awvalid  in  1  Vortex address valids
- core_arready, core_awready  out  1  gated readies to Vortex
- m_axi_arvalid, m_axi_awvalid  out  1  gated valids to NoC
- m_axi_arready, m_axi_awready  in  1  NoC readies
- m_axi_rvalid, m_axi_rready, m_axi_rlast  in  1  observed R channel
- m_axi_bvalid, m_axi_bready  in  1  observed B channel
- core_busy  in  1  Vortex busy
- core_reset_n  out  1  Vortex reset, active-low
- irq  out  1  level interrupt

Behaviour:
- Reset (reset=0), all registered state cleared:
  - CTRL=0; MAX_RD=MAX_WR=MAX_OUT_DEFAULT; counters=0.
  - prdata=0, pslverr=0, irq=0, core_reset_n=0.
- After reset deasserts, core_reset_n rises on the first clk edge with CTRL.soft_rst=0.
- Register map (word offsets):
  - 0x00 CTRL RW: [0] enable, [1] soft_rst, [2] irq_en. [3] clr_cnt is self-clearing and zeroes all counters next cycle.
  - 0x04 STATUS: [0] core_busy RO; [1] done W1C; [2] underflow_err W1C; [15:8] rd_out RO; [23:16] wr_out RO.
  - 0x08 LIMIT RW: [7:0] MAX_RD, [15:8] MAX_WR.
  - 0x0C RD_BURSTS RO; 0x10 WR_BURSTS RO; 0x14 BUSY_CYCLES RO.
- APB access:
  - Zero wait state: pready = psel & penable.
  - Writes commit on the access-phase edge.
  - prdata is registered in the setup phase (psel & !penable) and held through access; it is 0 otherwise.
  - Unmapped offsets: pslverr=1 during access, prdata=0, no side effects. Writes to RO fields are ignored, no error.
- Gating:
  - ar_allow = enable & (rd_out < MAX_RD).
  - m_axi_arvalid = core_arvalid & ar_gate; core_arready = m_axi_arready & ar_gate.
  - ar_gate is sampled from ar_allow only while no AR is pending. Pending means m_axi_arvalid=1 & m_axi_arready=0. While pending, ar_gate is held at 1, so an asserted valid never drops. The AW side is symmetric.
- Outstanding counters, 8-bit:
  - rd_out: +1 on AR handshake; -1 on R handshake with rlast; both in one cycle leaves it unchanged.
  - wr_out: +1 on AW handshake; -1 on B handshake.
  - A decrement at 0 is ignored and sets underflow_err.
  - Lowering LIMIT below the current count blocks new issue until drained; in-flight bursts are unaffected.
  - MAX=0 blocks all issue.
- Counters (CNT_W wide, saturating at all-ones):
  - RD_BURSTS +1 per rlast handshake; WR_BURSTS +1 per B handshake; BUSY_CYCLES +1 per cycle with core_busy=1.
  - clr_cnt has priority over increment.
- done is set on a core_busy 1->0 edge (core_busy registered once). A set coincident with W1C clear wins. irq = done & irq_en, registered.
- soft_rst:
  - core_reset_n = !soft_rst, registered.
  - Outstanding counters and gates clear while soft_rst=1; registers and perf counters are kept.
  - Software must drain traffic first. Responses arriving during soft_rst are ignored for counting.

Decomposition:
- Package gt_vortex_ctrl_pkg holds:
  - register offsets, CTRL/STATUS bit positions;
  - the LIMIT field layout and the MAX_OUT_DEFAULT bounds check.
- Sub-module axi_outstanding_tracker is instanced twice (AR/R and AW/B). It contains the gate hold, up/down counter, underflow flag and saturating burst counter. It is parametrised by CNT_W.

Test Plan:
- Reset, then APB read of 0x08 -> prdata=0x00001010, pslverr=0; core_reset_n=1 one cycle after reset release.
- CTRL=0x1, LIMIT=0x0202, core issues 3 ARs with m_axi_arready=1, no R -> exactly 2 handshakes, rd_out=2, third blocked. One rlast handshake -> third issues same/next cycle.
- m_axi_arvalid high with arready=0 while CTRL.enable written 0 -> arvalid stays 1 until handshake, then drops to 0.
- core_busy 1 for 100 cycles then 0, irq_en=1 -> BUSY_CYCLES=100, STATUS[1]=1, irq=1. Write 0x04=0x2 -> irq=0. W1C coincident with a new falling edge -> done stays 1.
- R handshake with rlast while rd_out=0 -> rd_out stays 0, STATUS[2]=1. APB read of 0x3C -> pslverr=1, prdata=0.
- Simultaneous AR handshake and rlast handshake at rd_out=1 -> rd_out=1, RD_BURSTS +1. CTRL clr_cnt -> all counters 0 next cycle, CTRL[3] reads 0.
